// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands a shared uart_tx to one requester per message,
// forwarding bytes one frame at a time and revoking stalled or unanswered grants.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned PAYLOAD_BITS  = 8,
    parameter int unsigned BUSY_TIMEOUT  = 4,
    parameter int unsigned GRANT_TIMEOUT = 65535
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy,
    output logic                            timeout_err
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned BCNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned GCNT_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_owner_q, last_owner_d;
    logic                    last_q, last_d;
    logic                    tx_en_q, tx_en_d;
    logic [PAYLOAD_BITS-1:0] tx_data_q, tx_data_d;
    logic                    timeout_q, timeout_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic [GCNT_W-1:0]       gcnt_q, gcnt_d;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand;
    logic                    own_valid;
    logic                    own_last;
    logic [PAYLOAD_BITS-1:0] own_data;
    logic                    accept;
    logic                    byte_done;

    // Round-robin search starting just after the previous message owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_owner_q) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Only the owner's lanes are looked at; everyone else is ignored.
    always_comb begin
        own_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                own_data = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign own_valid = |(req_valid & grant_q);
    assign own_last  = |(req_last & grant_q);
    assign accept    = (state_q == SEND) && own_valid && !uart_tx_busy;
    assign req_ready = (resetn && accept) ? grant_q : '0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        last_d       = last_q;
        tx_en_d      = 1'b0;
        tx_data_d    = tx_data_q;
        timeout_d    = 1'b0;
        bcnt_d       = bcnt_q;
        gcnt_d       = gcnt_q;
        byte_done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = SEND;
                    owner_d = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    gcnt_d  = '0;
                end
            end
            SEND: begin
                if (accept) begin
                    tx_data_d = own_data;
                    last_d    = own_last;
                    tx_en_d   = 1'b1;
                    bcnt_d    = '0;
                    gcnt_d    = '0;
                    state_d   = WAIT_BUSY;
                end else if (!own_valid) begin
                    // Owner went quiet: revoke the grant once the stall budget is spent.
                    if (gcnt_q == GCNT_W'(GRANT_TIMEOUT - 1)) begin
                        timeout_d    = 1'b1;
                        last_owner_d = owner_q;
                        grant_d      = '0;
                        gcnt_d       = '0;
                        state_d      = IDLE;
                    end else begin
                        gcnt_d = gcnt_q + GCNT_W'(1);
                    end
                end else begin
                    gcnt_d = '0;
                end
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (bcnt_q == BCNT_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    byte_done = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A finished byte either closes the message or returns for the next one.
        if (byte_done) begin
            gcnt_d = '0;
            if (last_q) begin
                state_d      = IDLE;
                last_owner_d = owner_q;
                grant_d      = '0;
            end else begin
                state_d = SEND;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            last_q       <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            timeout_q    <= 1'b0;
            bcnt_q       <= '0;
            gcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            last_q       <= last_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            timeout_q    <= timeout_d;
            bcnt_q       <= bcnt_d;
            gcnt_q       <= gcnt_d;
        end
    end

    assign grant        = grant_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = tx_data_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester traffic, a simple
// uart_tx busy model, and a monitor checking every strobe and timeout pulse.
module tb_uart_tx_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned PB    = 8;
    localparam int          FRAME = 6;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*PB-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic            uart_tx_en;
    logic [PB-1:0]   uart_tx_data;
    logic            busy = 1'b0;
    logic            timeout_err;

    logic            busy_dead = 1'b0;
    int              bcnt = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
    } tx_t;

    tx_t        exp_tx[$];
    logic [3:0] exp_to[$];
    logic [8:0] rq[N][$];
    logic [N-1:0] acc_pend = '0;
    logic [N-1:0] grant_prev = '0;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .PAYLOAD_BITS (PB),
        .BUSY_TIMEOUT (4),
        .GRANT_TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .uart_tx_en  (uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .uart_tx_busy(busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event not expected or never arrived", name);
    endtask

    task automatic enq(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic exp_strobe(input logic [3:0] g, input logic [7:0] d);
        tx_t t;
        t.g = g;
        t.d = d;
        exp_tx.push_back(t);
    endtask

    // uart_tx stand-in: busy rises the cycle after a strobe and lasts FRAME cycles.
    always @(posedge clk) begin
        if (!busy_dead && uart_tx_en === 1'b1) begin
            bcnt <= FRAME;
            busy <= 1'b1;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            bcnt <= 0;
            busy <= 1'b0;
        end
    end

    // Requester side: present queue heads, retire a byte once it was accepted.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (acc_pend[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        end
        for (int i = 0; i < N; i++) begin
            logic [8:0] h;
            if (rq[i].size() != 0) begin
                h = rq[i][0];
                req_valid[i] = 1'b1;
                req_data[i*PB +: PB] = h[7:0];
                req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        #1;
        acc_pend = req_ready;
        if (resetn && req_ready != '0)
            check("ready_owner", 32'(req_ready), 32'(grant & req_valid));
    end

    // Monitor: every strobe and timeout pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (resetn) begin
            if (uart_tx_en === 1'b1) begin
                if (exp_tx.size() == 0) fail_now("stray_strobe");
                else begin
                    tx_t t;
                    t = exp_tx.pop_front();
                    check("tx_grant", 32'(grant), 32'(t.g));
                    check("tx_data", 32'(uart_tx_data), 32'(t.d));
                end
            end
            if (timeout_err === 1'b1) begin
                if (exp_to.size() == 0) fail_now("stray_timeout");
                else check("timeout_grant", 32'(grant), 32'(exp_to.pop_front()));
            end
            if (grant !== grant_prev && grant != '0) begin
                check("grant_from_idle", 32'(grant_prev), 32'(0));
                check("grant_onehot", 32'($onehot(grant)), 32'(1));
                check("grant_busy_low", 32'(busy), 32'(0));
            end
        end
        grant_prev = grant;
    end

    task automatic do_reset();
        for (int k = 0; k < 50 && busy; k++) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_en(input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (uart_tx_en === 1'b1) return;
        end
        fail_now(name);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && exp_to.size() == 0 && grant == '0 && !busy) return;
        end
        fail_now(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        int   strobes;

        // Reset values and idle behaviour.
        do_reset();
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_tx_en", 32'(uart_tx_en), 32'(0));
        check("rst_tx_data", 32'(uart_tx_data), 32'(0));
        check("rst_timeout", 32'(timeout_err), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(0));
        repeat (5) @(negedge clk);
        check("idle_grant", 32'(grant), 32'(0));

        // Two single-byte messages, requester 0 first after reset.
        enq(0, 8'h41, 1'b1);
        enq(2, 8'h52, 1'b1);
        exp_strobe(4'b0001, 8'h41);
        exp_strobe(4'b0100, 8'h52);
        wait_drain("drain_basic");

        // Three-byte message holds the grant; requester 2 waits.
        do_reset();
        enq(1, 8'h10, 1'b0);
        enq(1, 8'h11, 1'b0);
        enq(1, 8'h12, 1'b1);
        enq(2, 8'h20, 1'b1);
        exp_strobe(4'b0010, 8'h10);
        exp_strobe(4'b0010, 8'h11);
        exp_strobe(4'b0010, 8'h12);
        exp_strobe(4'b0100, 8'h20);
        wait_drain("drain_message");

        // Everyone valid: order 0,1,2,3,0.
        do_reset();
        enq(0, 8'hA0, 1'b1);
        enq(0, 8'hB0, 1'b1);
        enq(1, 8'hA1, 1'b1);
        enq(2, 8'hA2, 1'b1);
        enq(3, 8'hA3, 1'b1);
        exp_strobe(4'b0001, 8'hA0);
        exp_strobe(4'b0010, 8'hA1);
        exp_strobe(4'b0100, 8'hA2);
        exp_strobe(4'b1000, 8'hA3);
        exp_strobe(4'b0001, 8'hB0);
        wait_drain("drain_rr");
        repeat (3) @(negedge clk);
        check("data_hold", 32'(uart_tx_data), 32'(8'hB0));

        // Busy never rises: timeout four cycles after each strobe.
        do_reset();
        busy_dead = 1'b1;
        enq(0, 8'h61, 1'b0);
        enq(0, 8'h62, 1'b1);
        exp_strobe(4'b0001, 8'h61);
        exp_strobe(4'b0001, 8'h62);
        exp_to.push_back(4'b0001);
        exp_to.push_back(4'b0000);
        for (int b = 0; b < 2; b++) begin
            wait_en("busy_to_strobe");
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                check("busy_to_timing", 32'(timeout_err), 32'(k == 4));
            end
        end
        wait_drain("drain_busy_to");
        busy_dead = 1'b0;

        // Owner stalls mid-message: grant revoked after 16 idle SEND cycles.
        do_reset();
        enq(0, 8'h71, 1'b0);
        enq(1, 8'h81, 1'b1);
        exp_strobe(4'b0001, 8'h71);
        exp_to.push_back(4'b0000);
        exp_strobe(4'b0010, 8'h81);
        wait_en("stall_strobe");
        for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
        for (int k = 0; k < 20 && busy; k++) @(negedge clk);
        early = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k < 17) early |= timeout_err;
        end
        check("grant_to_early", 32'(early), 32'(0));
        check("grant_to_pulse", 32'(timeout_err), 32'(1));
        check("grant_to_grant", 32'(grant), 32'(0));
        wait_drain("drain_grant_to");

        // Reset while granted: req_ready forced low, byte re-arbitrated afterwards.
        do_reset();
        enq(3, 8'hC3, 1'b1);
        exp_strobe(4'b1000, 8'hC3);
        for (int k = 0; k < 20 && grant == '0; k++) @(negedge clk);
        resetn = 1'b0;
        #2;
        check("ready_in_reset", 32'(req_ready), 32'(0));
        @(negedge clk);
        resetn = 1'b1;
        wait_drain("drain_ready_rst");

        // Reset during WAIT_DONE abandons the rest of the message.
        do_reset();
        enq(0, 8'h91, 1'b0);
        enq(0, 8'h92, 1'b1);
        exp_strobe(4'b0001, 8'h91);
        wait_en("wd_strobe");
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        rq[0].delete();
        @(negedge clk);
        check("wd_rst_grant", 32'(grant), 32'(0));
        check("wd_rst_tx_en", 32'(uart_tx_en), 32'(0));
        check("wd_rst_tx_data", 32'(uart_tx_data), 32'(0));
        check("wd_rst_timeout", 32'(timeout_err), 32'(0));
        resetn = 1'b1;
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (uart_tx_en === 1'b1) strobes++;
        end
        check("wd_no_strobe", 32'(strobes), 32'(0));

        check("sb_tx_empty", 32'(exp_tx.size()), 32'(0));
        check("sb_to_empty", 32'(exp_to.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8, width of one UART byte.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 4, cycles allowed for uart_tx_busy to rise after uart_tx_en.
REQ-004 SHALL have parameter GRANT_TIMEOUT, default 65535, idle cycles before a stalled grant is revoked.
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-008 SHALL have port req_data  input  NUM_REQ*PAYLOAD_BITS  per-requester byte; requester i uses bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-009 SHALL have port req_last  input  NUM_REQ  per-requester marker: the current byte ends the message.
REQ-010 SHALL have port req_ready  output  NUM_REQ  byte accepted from requester i this cycle.
REQ-011 SHALL have port grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
REQ-012 SHALL have port uart_tx_en  output  1  one-cycle start strobe to uart_tx.
REQ-013 SHALL have port uart_tx_data  output  PAYLOAD_BITS  registered byte to uart_tx.
REQ-014 SHALL have port uart_tx_busy  input  1  transmitter busy from uart_tx.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on a busy or grant timeout.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-017 SHALL, in IDLE, pick the first set req_valid bit, searching round-robin from (last_owner+1) mod NUM_REQ, then move to SEND with grant one-hot for that requester on the next cycle.
REQ-018 SHALL remain in IDLE with grant zero while req_valid is all zero.
REQ-019 SHALL drive req_ready[g] combinationally high only when state is SEND, grant[g] is 1, req_valid[g] is 1 and uart_tx_busy is 0; all other req_ready bits SHALL be 0.
REQ-020 SHALL, on an accept cycle, register the byte into uart_tx_data and the req_last bit internally, pulse uart_tx_en high for exactly the next cycle, and enter WAIT_BUSY.
REQ-021 SHALL, in WAIT_BUSY, enter WAIT_DONE when uart_tx_busy is 1.
REQ-022 SHALL, in WAIT_BUSY, pulse timeout_err and treat the byte as sent when uart_tx_busy stays 0 for BUSY_TIMEOUT cycles after the uart_tx_en cycle.
REQ-023 SHALL, in WAIT_DONE, wait for uart_tx_busy 0, then go to IDLE if the latched last bit is set (last_owner <= g, grant cleared) or to SEND otherwise.
REQ-024 SHALL hold the grant across the whole message; other requesters SHALL NOT be accepted until the owner's last byte completes.
REQ-025 SHALL count consecutive SEND cycles with req_valid[g] 0; at GRANT_TIMEOUT it SHALL pulse timeout_err, set last_owner <= g, clear grant and return to IDLE.
REQ-026 SHALL leave uart_tx_data unchanged when no byte is accepted.
REQ-027 SHALL ignore req_data, req_last and req_valid of non-granted requesters while not in IDLE.
REQ-028 SHALL accept at most one byte per uart_tx frame; back-to-back bytes are separated by at least one full busy period.

Reset
REQ-029 SHALL, on any rising clk edge with resetn 0, set state IDLE, grant 0, uart_tx_en 0, uart_tx_data 0, timeout_err 0, counters 0 and last_owner NUM_REQ-1, so requester 0 has first priority.
REQ-030 SHALL, on reset mid-message, abandon the message with no further uart_tx_en; req_ready SHALL be 0 while resetn is 0.

Verification
REQ-031 SHALL be verified with: after reset, req_valid=4'b0101, req_data0=8'h41, last0=1 -> grant=0001, one uart_tx_en with uart_tx_data=8'h41, then grant=0100 and its byte sent.
REQ-032 SHALL be verified with: requester 1 sends 3 bytes 8'h10,8'h11,8'h12 (last on third) while requester 2 holds valid -> three strobes in order, grant held, requester 2 granted only after busy falls on the third byte.
REQ-033 SHALL be verified with: all four requesters continuously valid with one-byte messages -> grant order 0,1,2,3,0.
REQ-034 SHALL be verified with: uart_tx_busy tied 0 -> timeout_err pulses 4 cycles after uart_tx_en and the state machine advances.
REQ-035 SHALL be verified with: owner drops req_valid mid-message with GRANT_TIMEOUT=16 -> timeout_err after 16 cycles, grant 0, next requester served.
REQ-036 SHALL be verified with: resetn low for 1 cycle during WAIT_DONE -> all outputs at reset values next cycle, no stray uart_tx_en.
